// File: rtl/if_stage.sv
// Instruction fetch stage: issues one instruction-memory request at a time,
// presents fetched instructions to decode through a one-entry output slot
// backed by a one-entry skid buffer, and handles redirects from execute.
//
// Handshake semantics (both interfaces):
//   decode side: an instruction moves when id_valid & id_ready at a rising
//   edge. id_valid never drops and id_instr/id_pc never change while id_valid=1
//   and id_ready=0, except when a redirect (pc_set) flushes the slot.
//   memory side: a request is accepted when imem_req & imem_gnt at a rising
//   edge. Exactly one imem_rvalid pulse answers each accepted request, at
//   the earliest one cycle after the grant.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_set,
    input  logic [31:0] pc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_npc,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    // Set when the outstanding response belongs to a fetch made stale by a redirect.
    logic        drop_q, drop_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    // The skid entry is occupied exactly when the FSM sits in HOLD.
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        imem_req_q, imem_req_d;

    logic        consume;

    assign consume   = out_valid_q & id_ready;

    assign imem_req  = imem_req_q;
    assign imem_addr = fetch_pc_q;
    assign id_valid  = out_valid_q;
    assign id_instr  = out_valid_q ? out_instr_q : NOP_INSTR;
    assign id_pc     = out_pc_q;
    assign id_npc    = out_pc_q + 32'd4;
    assign dbg_state = state_q;

    // Next-state and datapath logic; a redirect overrides everything but reset.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drop_d       = drop_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (consume) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else if (!out_valid_q || consume) begin
                        out_valid_d = 1'b1;
                        out_instr_d = imem_rdata;
                        out_pc_d    = fetch_pc_q;
                        fetch_pc_d  = fetch_pc_q + 32'd4;
                        state_d     = REQ;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = fetch_pc_q;
                        fetch_pc_d   = fetch_pc_q + 32'd4;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (consume) begin
                    out_valid_d = 1'b1;
                    out_instr_d = skid_instr_q;
                    out_pc_d    = skid_pc_q;
                    state_d     = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pc_set) begin
            fetch_pc_d  = pc_in;
            out_valid_d = 1'b0;
            case (state_q)
                REQ: begin
                    // A grant in the redirect cycle leaves a stale response in flight.
                    state_d = imem_gnt ? WAIT : REQ;
                    drop_d  = imem_gnt;
                end
                WAIT: begin
                    // Response arriving now is simply discarded; otherwise mark it stale.
                    state_d = imem_rvalid ? REQ : WAIT;
                    drop_d  = ~imem_rvalid;
                end
                default: begin
                    state_d = REQ;
                    drop_d  = 1'b0;
                end
            endcase
        end

        imem_req_d = (state_d == REQ);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            drop_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= NOP_INSTR;
            out_pc_q     <= 32'd0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'd0;
            imem_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drop_q       <= drop_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            imem_req_q   <= imem_req_d;
        end
    end

endmodule
